// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the memory bus sequencer and its testbench.
// Bus cycle states, cycle types and a small helper for sizing counters.
package mem_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } cyc_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Signals between the bus sequencer and the 16x8 memory / databus driver.
// The master drives address, strobes and write data; the slave returns the bus value.
interface mem_bus_if;
  import mem_bus_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;

  modport master (
    output address, wr, rd, data_out, data_oe,
    input  data_in
  );

  modport slave (
    input  address, wr, rd, data_out, data_oe,
    output data_in
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks while enabled.
// Disabling or clearing restarts the count so the next tick is a full period away.
module scan_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(DIV + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/mem_bus_master.sv
// Bus-cycle sequencer for the 16x8 memory: setup / strobe / hold timing for
// manual writes and reads, plus a scan mode that sweeps all addresses with reads.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int SCAN_DIV   = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              scan_en,
  mem_bus_if.master         bus,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

  state_e            state_q, state_d;
  cyc_e              type_q, type_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              scan_cyc_q, scan_cyc_d;
  logic              pending_q, pending_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              data_oe_q, data_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scan_en),
    .clr   (~scan_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      type_q      <= WR;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      scan_addr_q <= '0;
      scan_cyc_q  <= 1'b0;
      pending_q   <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      scan_addr_q <= scan_addr_d;
      scan_cyc_q  <= scan_cyc_d;
      pending_q   <= pending_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // A scan tick that lands mid-cycle is remembered until the bus is idle again.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    scan_addr_d = scan_addr_q;
    scan_cyc_d  = scan_cyc_q;
    pending_d   = pending_q;

    if (!scan_en)  pending_d = 1'b0;
    else if (tick) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (scan_en && (tick || pending_q)) begin
          state_d    = SETUP;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
          type_d     = RD;
          addr_d     = scan_addr_q;
          scan_cyc_d = 1'b1;
          pending_d  = 1'b0;
        end else if (!scan_en && start_wr) begin
          state_d    = SETUP;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
          type_d     = WR;
          addr_d     = cmd_addr;
          wdata_d    = cmd_data;
          scan_cyc_d = 1'b0;
        end else if (!scan_en && start_rd) begin
          state_d    = SETUP;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
          type_d     = RD;
          addr_d     = cmd_addr;
          scan_cyc_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          if (type_q == RD) rd_data_d = bus.data_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          scan_cyc_d = 1'b0;
          if (scan_cyc_q) scan_addr_d = scan_addr_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every pin comes straight from a flop.
  always_comb begin
    wr_d      = (state_d == STROBE) && (type_d == WR);
    rd_d      = (state_d == STROBE) && (type_d == RD);
    data_oe_d = (state_d != IDLE) && (type_d == WR);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == HOLD) && (state_d == IDLE);
  end

  assign bus.address  = addr_q;
  assign bus.wr       = wr_q;
  assign bus.rd       = rd_q;
  assign bus.data_out = wdata_q;
  assign bus.data_oe  = data_oe_q;
  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master driving a behavioural 16x8 memory on a resolved bus.
// Expected cycles are queued at issue time; a monitor checks each one when done pulses.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int DIV      = 16;
  localparam int BUSY_LEN = 8;
  localparam int STR_LEN  = 4;
  localparam int STR_OFS  = 2;

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
    bit         scan;
    bit         first;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_wr = 1'b0;
  logic       start_rd = 1'b0;
  logic       scan_en = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  mem_bus_if bus();
  wire [7:0] databus;
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];

  assign databus     = bus.data_oe ? bus.data_out : 8'hzz;
  assign databus     = bus.rd ? mem[bus.address] : 8'hzz;
  assign bus.data_in = databus;

  always @(posedge clk) if (bus.wr) mem[bus.address] <= databus;

  mem_bus_master #(
    .SETUP_CYC (2),
    .STROBE_CYC(4),
    .HOLD_CYC  (2),
    .SCAN_DIV  (DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_wr(start_wr),
    .start_rd(start_rd),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .scan_en (scan_en),
    .bus     (bus),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   dones  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: measures each bus cycle and checks it against the queued expectation.
  int         bcnt, wcnt, rcnt, oecnt, first_strobe;
  int         cyc = 0;
  int         last_launch = 0;
  int         gap = 0;
  logic [7:0] rd6;
  bit         busy_prev = 1'b0;

  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (!rst_n) begin
      busy_prev = 1'b0;
      bcnt = 0; wcnt = 0; rcnt = 0; oecnt = 0; first_strobe = -1;
    end else begin
      checks++;
      if ((bus.data_oe && bus.rd) || (bus.wr && bus.rd)) begin
        errors++;
        $display("[TB] FAIL bus_invariant: oe=%0b wr=%0b rd=%0b, expected oe&rd=0 and wr&rd=0",
                 bus.data_oe, bus.wr, bus.rd);
      end
      if (busy && !busy_prev) begin
        gap = cyc - last_launch;
        last_launch = cyc;
        bcnt = 0; wcnt = 0; rcnt = 0; oecnt = 0; first_strobe = -1;
      end
      if (busy) begin
        bcnt++;
        if ((bus.wr || bus.rd) && first_strobe < 0) first_strobe = bcnt - 1;
        if (bus.wr) wcnt++;
        if (bus.rd) rcnt++;
        if (bus.data_oe) oecnt++;
        if (bcnt == 7) rd6 = rd_data;
      end
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: addr=%0h with empty scoreboard", bus.address);
        end else begin
          t = sb.pop_front();
          checkOutput("address", 32'(bus.address), 32'(t.addr));
          checkOutput("busy_len", bcnt, BUSY_LEN);
          checkOutput("strobe_len", t.is_wr ? wcnt : rcnt, STR_LEN);
          checkOutput("other_strobe", t.is_wr ? rcnt : wcnt, 0);
          checkOutput("oe_len", oecnt, t.is_wr ? BUSY_LEN : 0);
          checkOutput("strobe_offset", first_strobe, STR_OFS);
          if (t.is_wr) begin
            checkOutput("mem_write", 32'(mem[t.addr]), 32'(t.data));
          end else begin
            checkOutput("rd_data_at_6", 32'(rd6), 32'(t.data));
            checkOutput("rd_data_hold", 32'(rd_data), 32'(t.data));
          end
          if (t.scan && !t.first) checkOutput("scan_gap", gap, DIV);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic pushTxn(input bit w, input logic [3:0] a, input logic [7:0] d, input bit sc, input bit fi);
    txn_t t;
    t.is_wr = w;
    t.addr  = a;
    t.scan  = sc;
    t.first = fi;
    if (w) begin
      ref_mem[a] = d;
      t.data = d;
    end else begin
      t.data = ref_mem[a];
    end
    sb.push_back(t);
    pushed++;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  // Drives one request at a negedge; the model expects write-over-read priority.
  task automatic applyStimulus(input bit w, input bit r, input logic [3:0] a, input logic [7:0] d);
    waitIdle();
    start_wr = w;
    start_rd = r;
    cmd_addr = a;
    cmd_data = d;
    if (w)      pushTxn(1'b1, a, d, 1'b0, 1'b0);
    else if (r) pushTxn(1'b0, a, d, 1'b0, 1'b0);
    @(negedge clk);
    start_wr = 1'b0;
    start_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_wr", 32'(bus.wr), 0);
    checkOutput("reset_rd", 32'(bus.rd), 0);
    checkOutput("reset_oe", 32'(bus.data_oe), 0);
    checkOutput("reset_addr", 32'(bus.address), 0);
    checkOutput("reset_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 4'h3, 8'hA5);
    applyStimulus(1'b0, 1'b1, 4'h3, 8'h00);

    applyStimulus(1'b1, 1'b1, 4'h5, 8'h3C);
    @(negedge clk);
    start_rd = 1'b1;
    cmd_addr = 4'h7;
    @(negedge clk);
    start_rd = 1'b0;

    applyStimulus(1'b1, 1'b0, 4'h9, 8'h5A);
    n = 0;
    while (!bus.wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wr_seen_before_reset", 32'(bus.wr), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_wr", 32'(bus.wr), 0);
    checkOutput("async_rst_oe", 32'(bus.data_oe), 0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    checkOutput("async_rst_addr", 32'(bus.address), 0);
    checkOutput("async_rst_data_out", 32'(bus.data_out), 0);
    checkOutput("async_rst_rd_data", 32'(rd_data), 0);
    pushed = pushed - sb.size();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy), 0);
    checkOutput("post_rst_rd_data", 32'(rd_data), 0);
    applyStimulus(1'b0, 1'b1, 4'h9, 8'h00);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 4'(i), 8'(i * 17));
    waitIdle();

    for (int i = 0; i < 17; i++) pushTxn(1'b0, 4'(i % 16), 8'h00, 1'b1, i == 0);
    scan_en = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 17 * DIV + 64) begin
      @(negedge clk);
      n++;
      if (n == 40) begin
        start_wr = 1'b1;
        cmd_addr = 4'hE;
        cmd_data = 8'h00;
      end else begin
        start_wr = 1'b0;
      end
    end
    scan_en  = 1'b0;
    start_wr = 1'b0;
    checkOutput("scan_drained", sb.size(), 0);

    for (int i = 0; i < 24; i++) begin
      bit w;
      w = 1'($urandom % 2);
      applyStimulus(w, !w, 4'($urandom % 16), 8'($urandom));
    end

    waitIdle();
    repeat (30) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("done_count", dones, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Synchronous bus-cycle sequencer that sits directly upstream of the lab's 16x8 `memory` module and generates its `address`, `wr`, `rd` and write-data enable with guaranteed setup, strobe and hold intervals. It replaces the raw button/DIP wiring to the memory: manual write/read commands come from debounced front-panel pulses, and a scan mode replaces the free-running slow counter, sweeping all 16 addresses. Read data is captured into a register for the seven-segment display path. Top level owns the tristate: `databus = data_oe ? data_out : 8'hZZ`.

## Interface
Parameters:
- SETUP_CYC, 2, cycles address/data are stable before strobe (>=1)
- STROBE_CYC, 4, cycles `wr`/`rd` held high (>=1)
- HOLD_CYC, 2, cycles address/data held after strobe falls (>=1)
- SCAN_DIV, 25_000_000, clocks between scan-read launches (>=SETUP_CYC+STROBE_CYC+HOLD_CYC+1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_wr  in  1  one-cycle write request
- start_rd  in  1  one-cycle read request
- cmd_addr  in  4  address for manual commands
- cmd_data  in  8  write data for manual commands
- scan_en  in  1  1 = scan mode, manual commands ignored
- data_in  in  8  databus as seen by this block
- address  out  4  memory address
- wr  out  1  write strobe, active-high
- rd  out  1  read strobe, active-high
- data_out  out  8  write data to databus driver
- data_oe  out  1  enable for top-level databus driver
- rd_data  out  8  last captured read value
- busy  out  1  bus cycle in progress
- done  out  1  one-cycle pulse at cycle completion

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter loaded on each state entry.
- IDLE: accepts a command when no cycle is active. Priority: scan tick (scan_en=1) > start_wr > start_rd. Simultaneous start_wr & start_rd: write executes, read dropped. Requests arriving while busy are dropped (no queue).
- On accept: latch address (cmd_addr or scan_addr), data_out (cmd_data, writes only), cycle type; go to SETUP.
- SETUP (SETUP_CYC cycles): address valid; data_oe=1 for writes; wr=rd=0.
- STROBE (STROBE_CYC cycles): wr=1 (write) or rd=1 (read). Read: data_in sampled into rd_data on the last STROBE cycle edge.
- HOLD (HOLD_CYC cycles): strobes 0; address, data_out, data_oe unchanged.
- HOLD exit -> IDLE, done=1 for that one cycle, data_oe=0.
- Invariant: data_oe and rd never high together; data_oe=0 for every read cycle.
- Scan mode: scan_addr (4 bit) starts 0; tick every SCAN_DIV clocks while scan_en=1; each tick launches a read of scan_addr; scan_addr increments on that read's done, wrapping 15 -> 0. scan_en falling mid-cycle: current cycle completes normally; scan_addr retained; prescaler cleared. Tick arriving while busy is held pending until IDLE.
- Reset (any time, including mid-strobe): all outputs 0 immediately — address=0, wr=0, rd=0, data_out=0, data_oe=0, rd_data=0, busy=0, done=0; state IDLE, scan_addr=0, prescaler=0.

## Timing
- Request sampled at edge N; address/data_oe valid after edge N; busy=1 from edge N.
- wr/rd rise after edge N+SETUP_CYC, fall after edge N+SETUP_CYC+STROBE_CYC.
- busy high for exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; done coincides with first IDLE cycle; a new request may be accepted in the done cycle.
- rd_data updates at edge N+SETUP_CYC+STROBE_CYC, holds until next read.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Shared package `mem_bus_pkg`: ADDR_W=4, DATA_W=8, state enum (IDLE/SETUP/STROBE/HOLD), cycle-type enum (WR/RD).
- One sub-module: `scan_tick_gen` (SCAN_DIV prescaler, enable, synchronous clear, one-cycle tick out).

## Test plan
Use SETUP_CYC=2, STROBE_CYC=4, HOLD_CYC=2, SCAN_DIV=16, behavioural 16x8 memory on a resolved bus.
- start_wr, cmd_addr=4'h3, cmd_data=8'hA5 -> wr high 4 cycles starting 2 after accept, data_oe high 8 cycles, done at cycle 9; memory[3]=8'hA5.
- Then start_rd, cmd_addr=4'h3 -> rd high 4 cycles, data_oe never high, rd_data=8'hA5 at cycle 6, done cycle 9.
- start_wr and start_rd same cycle (addr 5, data 8'h3C) -> only write cycle; memory[5]=8'h3C; no rd pulse. start_rd during busy -> ignored.
- scan_en=1 with memory[i]=i*8'h11 -> reads of addr 0,1,...,15,0 every 16 cycles; rd_data sequence 8'h00,8'h11,...,8'hFF,8'h00 (wrap).
- rst_n low during STROBE of a write -> wr, data_oe, busy drop same cycle (async); after release, state IDLE, rd_data=0, next command runs normally.
- Assertion across all tests: never (data_oe && rd); wr and rd never both high.
